// File: rtl/framebuffer_scan_ram.sv
// Single-clock framebuffer: random-access host writes, raster scan out over ready/valid with X/Y replication.
// Optional fill engine enabled by defining FB_SCAN_CLEAR_EN.
module framebuffer_scan_ram #(
  parameter int unsigned H_RES      = 160,
  parameter int unsigned V_RES      = 120,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned SCALE_X    = 1,
  parameter int unsigned SCALE_Y    = 1,
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [PIX_W-1:0]      wr_data,
  output logic                  wr_busy,
  input  logic                  sof,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [PIX_W-1:0]      pix_data,
  output logic                  pix_eol,
  output logic                  pix_eof,
  input  logic                  clr_start,
  input  logic [PIX_W-1:0]      clr_color,
  output logic                  clr_busy
);

  localparam int unsigned DEPTH  = H_RES * V_RES;
  localparam int unsigned RAM_AW = (DEPTH   > 1) ? $clog2(DEPTH)   : 1;
  localparam int unsigned XW     = (H_RES   > 1) ? $clog2(H_RES)   : 1;
  localparam int unsigned YW     = (V_RES   > 1) ? $clog2(V_RES)   : 1;
  localparam int unsigned RXW    = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int unsigned RYW    = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
  localparam int unsigned ENT_W  = PIX_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e                state_q;
  logic [XW-1:0]         x_q;
  logic [RXW-1:0]        rx_q;
  logic [YW-1:0]         y_q;
  logic [RYW-1:0]        ry_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  infl_q, infl_eol_q, infl_eof_q;
  logic [PIX_W-1:0]      rdata_q;
  logic [ENT_W-1:0]      ent0_q, ent1_q, ent0_d, ent1_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  valid_q;

  logic [XW-1:0]         cx, nx;
  logic [RXW-1:0]        crx, nrx;
  logic [YW-1:0]         cy, ny;
  logic [RYW-1:0]        cry, nry;
  logic [ADDR_WIDTH-1:0] cbase, nbase, rd_addr;
  logic                  pop, issue, eol_n, last_n;
  logic                  x_end, rx_end, y_end, ry_end;
  logic [2:0]            occ;

  logic                  ram_we;
  logic [RAM_AW-1:0]     ram_wa;
  logic [PIX_W-1:0]      ram_wd;
  logic                  host_we;
  logic [PIX_W-1:0]      mem [DEPTH];

  // Scan position for the read issued this cycle; sof restarts from pixel 0 immediately.
  always_comb begin
    cx    = x_q;
    crx   = rx_q;
    cy    = y_q;
    cry   = ry_q;
    cbase = base_q;
    if (sof) begin
      cx    = '0;
      crx   = '0;
      cy    = '0;
      cry   = '0;
      cbase = '0;
    end
    pop     = valid_q & pix_ready;
    occ     = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    issue   = sof | ((state_q == S_RUN) & (occ < 3'd2));
    rd_addr = cbase + ADDR_WIDTH'(cx);
    x_end   = (cx  == XW'(H_RES - 1));
    rx_end  = (crx == RXW'(SCALE_X - 1));
    y_end   = (cy  == YW'(V_RES - 1));
    ry_end  = (cry == RYW'(SCALE_Y - 1));
    eol_n   = x_end & rx_end;
    last_n  = eol_n & ry_end & y_end;

    nx    = cx;
    nrx   = crx;
    ny    = cy;
    nry   = cry;
    nbase = cbase;
    if (!rx_end) begin
      nrx = crx + RXW'(1);
    end else begin
      nrx = '0;
      if (!x_end) begin
        nx = cx + XW'(1);
      end else begin
        nx = '0;
        if (!ry_end) begin
          nry = cry + RYW'(1);
        end else begin
          nry   = '0;
          ny    = cy + YW'(1);
          nbase = cbase + ADDR_WIDTH'(H_RES);
        end
      end
    end
  end

  // Two-entry output buffer: entry 0 drives the outputs, RAM data lands one cycle after issue.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (pop) begin
      ent0_d = ent1_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (infl_q) begin
      if (cnt_d == 2'd0) ent0_d = {rdata_q, infl_eol_q, infl_eof_q};
      else               ent1_d = {rdata_q, infl_eol_q, infl_eof_q};
      cnt_d = cnt_d + 2'd1;
    end
    if (sof) cnt_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      rx_q       <= '0;
      y_q        <= '0;
      ry_q       <= '0;
      base_q     <= '0;
      infl_q     <= 1'b0;
      infl_eol_q <= 1'b0;
      infl_eof_q <= 1'b0;
      ent0_q     <= '0;
      ent1_q     <= '0;
      cnt_q      <= 2'd0;
      valid_q    <= 1'b0;
    end else begin
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      cnt_q      <= cnt_d;
      valid_q    <= (cnt_d != 2'd0);
      infl_q     <= issue;
      infl_eol_q <= eol_n;
      infl_eof_q <= last_n;
      if (issue) begin
        x_q    <= nx;
        rx_q   <= nrx;
        y_q    <= ny;
        ry_q   <= nry;
        base_q <= nbase;
      end
      case (state_q)
        S_IDLE:  if (sof) state_q <= last_n ? S_DRAIN : S_RUN;
        S_RUN:   if (issue && last_n) state_q <= S_DRAIN;
        S_DRAIN: begin
          if (sof)                          state_q <= last_n ? S_DRAIN : S_RUN;
          else if (cnt_q == 2'd0 && !infl_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pix_valid = valid_q;
  assign pix_data  = ent0_q[ENT_W-1:2];
  assign pix_eol   = ent0_q[1];
  assign pix_eof   = ent0_q[0];

  assign host_we = wr_en & ~wr_busy & (32'(wr_addr) < DEPTH);

`ifdef FB_SCAN_CLEAR_EN
  logic              clr_busy_q;
  logic [RAM_AW-1:0] clr_addr_q;
  logic [PIX_W-1:0]  clr_color_q;

  // Fill engine: one address per cycle, owns the write port while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_busy_q  <= 1'b0;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
    end else if (!clr_busy_q) begin
      if (clr_start) begin
        clr_busy_q  <= 1'b1;
        clr_addr_q  <= '0;
        clr_color_q <= clr_color;
      end
    end else if (clr_addr_q == RAM_AW'(DEPTH - 1)) begin
      clr_busy_q <= 1'b0;
    end else begin
      clr_addr_q <= clr_addr_q + RAM_AW'(1);
    end
  end

  assign clr_busy = clr_busy_q;
  assign wr_busy  = clr_busy_q;
  assign ram_we   = clr_busy_q | host_we;
  assign ram_wa   = clr_busy_q ? clr_addr_q  : RAM_AW'(wr_addr);
  assign ram_wd   = clr_busy_q ? clr_color_q : wr_data;
`else
  logic unused_clr;
  assign unused_clr = ^{clr_start, clr_color};
  assign clr_busy   = 1'b0;
  assign wr_busy    = 1'b0;
  assign ram_we     = host_we;
  assign ram_wa     = RAM_AW'(wr_addr);
  assign ram_wd     = wr_data;
`endif

  // Read-first block RAM; contents deliberately unreset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
    if (issue)  rdata_q <= mem[RAM_AW'(rd_addr)];
  end

endmodule

// File: tb/tb_framebuffer_scan_ram.sv
// Bench for framebuffer_scan_ram: 4x2 frame at scale 1 (u_dut1) and scale 2x2 (u_dut2) against a raster model.
module tb_framebuffer_scan_ram;
  localparam int H = 4;
  localparam int V = 2;
  localparam int N = H * V;
  localparam int MAX_CYC = 400;

  typedef struct packed { logic [7:0] d; logic eol; logic eof; } pix_t;

  logic       clk = 1'b0;
  logic       rst, wr_en, sof1, sof2, rdy1, rdy2, clr_start;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, clr_color;
  logic       pv1, peol1, peof1, wb1, cb1;
  logic       pv2, peol2, peof2, wb2, cb2;
  logic [7:0] pd1, pd2;

  logic [7:0] model [N];
  pix_t       exp_q[$];
  pix_t       got_q[$];
  int         cmp_cnt = 0;
  int         err_cnt = 0;

  always #5 clk = ~clk;

  framebuffer_scan_ram #(.H_RES(H), .V_RES(V), .PIX_W(8), .SCALE_X(1), .SCALE_Y(1), .ADDR_WIDTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_busy(wb1),
    .sof(sof1), .pix_valid(pv1), .pix_ready(rdy1), .pix_data(pd1), .pix_eol(peol1), .pix_eof(peof1),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(cb1));

  framebuffer_scan_ram #(.H_RES(H), .V_RES(V), .PIX_W(8), .SCALE_X(2), .SCALE_Y(2), .ADDR_WIDTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_busy(wb2),
    .sof(sof2), .pix_valid(pv2), .pix_ready(rdy2), .pix_data(pd2), .pix_eol(peol2), .pix_eof(peof2),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(cb2));

  // Expected output stream straight from the raster definition.
  task automatic build_expected(input int sx, input int sy);
    pix_t p;
    exp_q.delete();
    for (int y = 0; y < V; y++)
      for (int ry = 0; ry < sy; ry++)
        for (int x = 0; x < H; x++)
          for (int rx = 0; rx < sx; rx++) begin
            p.d   = model[y*H + x];
            p.eol = (x == H-1) && (rx == sx-1);
            p.eof = p.eol && (y == V-1) && (ry == sy-1);
            exp_q.push_back(p);
          end
  endtask

  task automatic write_pix(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (a < 4'(N)) model[a] = d;
  endtask

  task automatic fill_random();
    for (int a = 0; a < N; a++) write_pix(4'(a), 8'($urandom));
  endtask

  // Pulses sof on the selected DUT and records accepted pixels; cycle c counts from T.
  task automatic collect(input int sel, input int mode, input int stop_after, input int wr_cycle,
                         input logic [3:0] wa, input logic [7:0] wd,
                         output int first_c, output int last_c, output int stall_err, output bit to);
    pix_t cur, held;
    bit   hold, rdy, v, done;
    got_q.delete();
    first_c = -1; last_c = -1; stall_err = 0; hold = 0; done = 0;
    @(posedge clk); #1;
    if (sel == 0) begin sof1 = 1'b1; rdy1 = 1'b1; end
    else          begin sof2 = 1'b1; rdy2 = 1'b1; end
    for (int c = 1; c <= MAX_CYC && !done; c++) begin
      @(posedge clk); #1;
      sof1 = 1'b0; sof2 = 1'b0;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 4 == 1) || (c % 4 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (sel == 0) rdy1 = rdy; else rdy2 = rdy;
      wr_en = (c == wr_cycle); wr_addr = wa; wr_data = wd;
      @(negedge clk);
      if (sel == 0) begin v = pv1; cur = {pd1, peol1, peof1}; end
      else          begin v = pv2; cur = {pd2, peol2, peof2}; end
      if (hold && (!v || cur !== held)) stall_err++;
      if (v && first_c < 0) first_c = c;
      if (v && rdy) begin
        got_q.push_back(cur);
        if (cur.eof || got_q.size() == stop_after) begin done = 1; last_c = c; end
      end
      hold = v && !rdy;
      held = cur;
    end
    wr_en = 1'b0;
    to = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_cnt++;
    if ({pv1, pv2} !== 2'b00) begin err_cnt++; $display("FAIL reset_valid got %b want 00", {pv1, pv2}); end
    cmp_cnt++;
    if ({pd1, peol1, peof1} !== 10'd0) begin err_cnt++; $display("FAIL reset_data got %h/%b/%b want 0", pd1, peol1, peof1); end
    cmp_cnt++;
    if ({wb1, cb1, wb2, cb2} !== 4'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0000", {wb1, cb1, wb2, cb2}); end
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cmp_cnt++;
      if (pv1 !== 1'b0) begin err_cnt++; $display("FAIL idle_valid got %b want 0", pv1); end
    end
  endtask

  task automatic test_basic();
    int fc, lc, se; bit to;
    for (int a = 0; a < N; a++) write_pix(4'(a), 8'(a));
    build_expected(1, 1);
    collect(0, 0, 0, -1, 4'd0, 8'd0, fc, lc, se, to);
    cmp_cnt++;
    if (to) begin err_cnt++; $display("FAIL basic_timeout got no eof want eof"); end
    cmp_cnt++;
    if (fc != 2) begin err_cnt++; $display("FAIL basic_latency got T+%0d want T+2", fc); end
    cmp_cnt++;
    if (lc - fc != N - 1) begin err_cnt++; $display("FAIL basic_bubbles got span %0d want %0d", lc - fc, N - 1); end
    cmp_cnt++;
    if (got_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL basic_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      cmp_cnt++;
      if (got_q[i] !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL basic_pix[%0d] got %h/%b/%b want %h/%b/%b", i, got_q[i].d, got_q[i].eol, got_q[i].eof, exp_q[i].d, exp_q[i].eol, exp_q[i].eof);
      end
    end
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      cmp_cnt++;
      if (pv1 !== 1'b0) begin err_cnt++; $display("FAIL basic_after_frame got valid %b want 0", pv1); end
    end
  endtask

  task automatic test_scale();
    int fc, lc, se; bit to;
    build_expected(2, 2);
    collect(1, 0, 0, -1, 4'd0, 8'd0, fc, lc, se, to);
    cmp_cnt++;
    if (to || fc != 2 || lc - fc != 31) begin err_cnt++; $display("FAIL scale_timing got to=%b first=%0d span=%0d want 0/2/31", to, fc, lc - fc); end
    cmp_cnt++;
    if (got_q.size() != 32) begin err_cnt++; $display("FAIL scale_len got %0d want 32", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      cmp_cnt++;
      if (got_q[i] !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL scale_pix[%0d] got %h/%b/%b want %h/%b/%b", i, got_q[i].d, got_q[i].eol, got_q[i].eof, exp_q[i].d, exp_q[i].eol, exp_q[i].eof);
      end
    end
  endtask

  task automatic test_stall();
    int fc, lc, se; bit to;
    fill_random();
    build_expected(1, 1);
    collect(0, 1, 0, -1, 4'd0, 8'd0, fc, lc, se, to);
    cmp_cnt++;
    if (to || se != 0) begin err_cnt++; $display("FAIL stall_hold got to=%b unstable=%0d want 0/0", to, se); end
    cmp_cnt++;
    if (got_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL stall_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      cmp_cnt++;
      if (got_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL stall_pix[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int fc, lc, se; bit to;
    for (int r = 0; r < 3; r++) begin
      fill_random();
      build_expected(2, 2);
      collect(1, 2, 0, -1, 4'd0, 8'd0, fc, lc, se, to);
      cmp_cnt++;
      if (to || se != 0 || got_q.size() != exp_q.size()) begin
        err_cnt++;
        $display("FAIL random_run%0d got to=%b unstable=%0d len=%0d want 0/0/%0d", r, to, se, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        cmp_cnt++;
        if (got_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL random_pix%0d[%0d] got %h want %h", r, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_abort();
    int fc, lc, se; bit to;
    fill_random();
    build_expected(1, 1);
    collect(0, 0, 3, -1, 4'd0, 8'd0, fc, lc, se, to);
    cmp_cnt++;
    if (to || got_q.size() != 3) begin err_cnt++; $display("FAIL abort_prefix got to=%b len=%0d want 0/3", to, got_q.size()); end
    collect(0, 0, 0, -1, 4'd0, 8'd0, fc, lc, se, to);
    cmp_cnt++;
    if (to || fc != 2) begin err_cnt++; $display("FAIL abort_restart got to=%b first=T+%0d want 0/T+2", to, fc); end
    cmp_cnt++;
    if (got_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL abort_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      cmp_cnt++;
      if (got_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL abort_pix[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    collect(0, 0, 2, -1, 4'd0, 8'd0, fc, lc, se, to);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      cmp_cnt++;
      if (pv1 !== 1'b0) begin err_cnt++; $display("FAIL rst_midframe_valid got %b want 0", pv1); end
      @(posedge clk);
    end
  endtask

  task automatic test_write_boundary();
    int fc, lc, se; bit to;
    logic [7:0] nv;
    fill_random();
    write_pix(4'd8, ~model[0]);
    build_expected(1, 1);
    nv = ~model[2];
    collect(0, 0, 0, 2, 4'd2, nv, fc, lc, se, to);
    cmp_cnt++;
    if (to || got_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL wb_len got to=%b len=%0d want 0/%0d", to, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      cmp_cnt++;
      if (got_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL wb_old_pix[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    model[2] = nv;
    build_expected(1, 1);
    collect(0, 0, 0, -1, 4'd0, 8'd0, fc, lc, se, to);
    cmp_cnt++;
    if (to || got_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL wb_new_len got to=%b len=%0d want 0/%0d", to, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      cmp_cnt++;
      if (got_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL wb_new_pix[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_clear();
    int fc, lc, se; bit to;
    bit want;
    clr_color = 8'hE0;
    @(posedge clk); #1; clr_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      clr_start = (c == 3);
      if (c == 1) clr_color = 8'h11;
      wr_en = (c == 1); wr_addr = 4'd5; wr_data = 8'h55;
      @(negedge clk);
`ifdef FB_SCAN_CLEAR_EN
      want = (c <= N);
`else
      want = 1'b0;
`endif
      cmp_cnt++;
      if (cb1 !== want || wb1 !== want) begin err_cnt++; $display("FAIL clear_busy c=%0d got %b/%b want %b", c, cb1, wb1, want); end
    end
    wr_en = 1'b0; clr_start = 1'b0;
`ifdef FB_SCAN_CLEAR_EN
    for (int a = 0; a < N; a++) model[a] = 8'hE0;
`else
    model[5] = 8'h55;
`endif
    build_expected(1, 1);
    collect(0, 0, 0, -1, 4'd0, 8'd0, fc, lc, se, to);
    cmp_cnt++;
    if (to || got_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL clear_frame_len got to=%b len=%0d want 0/%0d", to, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      cmp_cnt++;
      if (got_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL clear_pix[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    clr_color = 8'h3C;
    @(posedge clk); #1; clr_start = 1'b1;
    @(posedge clk); #1; clr_start = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (cb1 !== 1'b0 || wb1 !== 1'b0) begin err_cnt++; $display("FAIL clear_rst_abort got %b/%b want 0/0", cb1, wb1); end
    fill_random();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    sof1 = 1'b0; sof2 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    clr_start = 1'b0; clr_color = '0;
    test_reset();
    test_basic();
    test_scale();
    test_stall();
    test_random();
    test_abort();
    test_write_boundary();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want $finish before 500us");
    $fatal(1, "watchdog");
  end

endmodule
